// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer slice.
// Optional RAS error detection: PC_SEQ_RAS_ERR_EN.
package pc_seq_pkg;

  localparam int WORD_W      = 32;
  localparam int INSTR_BYTES = 4;

  typedef logic [WORD_W-1:0] addr_t;

  localparam addr_t RESET_PC_DEF = 32'h0000_0000;

endpackage

// File: rtl/pc_seq_if.sv
// Decoder <-> PC sequencer bundle.
// master = jump decoder, slave = sequencer.
interface pc_seq_if;
  import pc_seq_pkg::*;

  logic  Stall;
  logic  PCSrc;
  addr_t JmpAddr;
  logic  IsCall;
  logic  IsRet;
  addr_t PC;
  addr_t PCPlus4;
  addr_t ResumeAddr;
  logic  RasEmpty;
  logic  RasFull;
  logic  RasErr;

  modport master (
    output Stall, PCSrc, JmpAddr,
    output IsCall, IsRet,
    input  PC, PCPlus4, ResumeAddr,
    input  RasEmpty, RasFull, RasErr
  );

  modport slave (
    input  Stall, PCSrc, JmpAddr,
    input  IsCall, IsRet,
    output PC, PCPlus4, ResumeAddr,
    output RasEmpty, RasFull, RasErr
  );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack with sticky error flag.
// Error detection built only with PC_SEQ_RAS_ERR_EN.
module ras_stack
  import pc_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  push,
  input  logic  pop,
  input  addr_t din,
  output addr_t top,
  output logic  empty,
  output logic  full,
  output logic  err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] P1 = 1;
  localparam logic [PW:0]   C1 = 1;
  localparam logic [PW:0]   CMAX = (PW+1)'(DEPTH);

  logic [PW-1:0] wp;
  logic [PW-1:0] tp;
  logic [PW:0]   cnt;
  addr_t         mem [DEPTH];

  logic do_push;
  logic do_pop;
  logic do_rep;

  assign tp    = wp - P1;
  assign empty = (cnt == '0);
  assign full  = (cnt == CMAX);
  assign top   = empty ? '0 : mem[tp];

  always_comb begin
    do_push = en & push & ~pop;
    do_pop  = en & pop & ~push;
    do_rep  = en & push & pop;
  end

  // Replace-on-empty degenerates to a plain push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      cnt <= '0;
    end else if (do_push || (do_rep && empty)) begin
      mem[wp] <= din;
      wp      <= wp + P1;
      if (!full)
        cnt <= cnt + C1;
    end else if (do_rep) begin
      mem[tp] <= din;
    end else if (do_pop && !empty) begin
      wp  <= wp - P1;
      cnt <= cnt - C1;
    end
  end

`ifdef PC_SEQ_RAS_ERR_EN
  logic ovf;
  logic unf;
  logic err_q;

  assign ovf = do_push & full;
  assign unf = (do_pop | do_rep) & empty;

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (ovf || unf)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register, next-PC mux and return-address stack.
// Optional sticky RAS error flag: PC_SEQ_RAS_ERR_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int    RAS_DEPTH = 8,
  parameter addr_t RESET_PC  = RESET_PC_DEF
) (
  input  logic     clk,
  input  logic     reset,
  pc_seq_if.slave  bus
);

  addr_t pc_q;
  addr_t pc_p4;
  logic  run;

  assign run   = ~bus.Stall;
  assign pc_p4 = pc_q + addr_t'(INSTR_BYTES);

  always_ff @(posedge clk) begin
    if (reset)
      pc_q <= RESET_PC;
    else if (run)
      pc_q <= bus.PCSrc ? bus.JmpAddr : pc_p4;
  end

  ras_stack #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .reset (reset),
    .en    (run),
    .push  (bus.IsCall),
    .pop   (bus.IsRet),
    .din   (pc_p4),
    .top   (bus.ResumeAddr),
    .empty (bus.RasEmpty),
    .full  (bus.RasFull),
    .err   (bus.RasErr)
  );

  assign bus.PC      = pc_q;
  assign bus.PCPlus4 = pc_p4;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (RAS_DEPTH=8,
// RESET_PC=32'h0040_0000), works with or without PC_SEQ_RAS_ERR_EN.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

`ifdef PC_SEQ_RAS_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  typedef struct {
    addr_t pc;
    addr_t p4;
    addr_t res;
    logic  e;
    logic  f;
    logic  r;
    string name;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_chk;
  int   n_pass;

  pc_seq_if bus();

  pc_sequencer #(
    .RAS_DEPTH (8),
    .RESET_PC  (32'h0040_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: samples 1 time unit after every rising edge.
  initial begin
    exp_t x;
    n_chk  = 0;
    n_pass = 0;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        n_chk++;
        if (bus.PC === x.pc && bus.PCPlus4 === x.p4 &&
            bus.ResumeAddr === x.res &&
            bus.RasEmpty === x.e && bus.RasFull === x.f &&
            bus.RasErr === x.r)
          n_pass++;
        else
          $display("FAIL %s: got pc=%h p4=%h res=%h e=%b f=%b r=%b want pc=%h p4=%h res=%h e=%b f=%b r=%b",
                   x.name, bus.PC, bus.PCPlus4, bus.ResumeAddr,
                   bus.RasEmpty, bus.RasFull, bus.RasErr,
                   x.pc, x.p4, x.res, x.e, x.f, x.r);
      end
    end
  end

  task automatic step(
    input logic  rst,
    input logic  st,
    input logic  src,
    input addr_t jmp,
    input logic  call,
    input logic  ret,
    input addr_t epc,
    input addr_t eres,
    input logic  ee,
    input logic  ef,
    input logic  er,
    input string name
  );
    exp_t x;
    reset       = rst;
    bus.Stall   = st;
    bus.PCSrc   = src;
    bus.JmpAddr = jmp;
    bus.IsCall  = call;
    bus.IsRet   = ret;
    x.pc   = epc;
    x.p4   = epc + 32'd4;
    x.res  = eres;
    x.e    = ee;
    x.f    = ef;
    x.r    = er;
    x.name = name;
    sb.push_back(x);
    @(posedge clk);
    #2;
  endtask

  initial begin
    int w;
    // reset then idle advance
    step(1,0,0,32'h0,0,0, 32'h0040_0000,0,1,0,0,"reset");
    step(0,0,0,32'h0,0,0, 32'h0040_0004,0,1,0,0,"idle1");
    step(0,0,0,32'h0,0,0, 32'h0040_0008,0,1,0,0,"idle2");
    // redirect and stall
    step(0,0,1,32'h1000,0,0, 32'h1000,0,1,0,0,"redirect");
    step(0,1,1,32'h2000,0,0, 32'h1000,0,1,0,0,"stall_jmp");
    step(0,1,1,32'h2000,1,0, 32'h1000,0,1,0,0,"stall_call");
    step(0,0,1,32'h100,0,0, 32'h100,0,1,0,0,"to_100");
    // nested calls and returns
    step(0,0,1,32'h200,1,0, 32'h200,32'h104,0,0,0,"call1");
    step(0,0,1,32'h500,1,0, 32'h500,32'h204,0,0,0,"call2");
    step(0,0,1,32'h204,0,1, 32'h204,32'h104,0,0,0,"ret1");
    step(0,0,1,32'h104,0,1, 32'h104,0,1,0,0,"ret2");
    step(0,0,0,32'h0,0,1, 32'h108,0,1,0,ERR_ON,"pop_empty");
    step(0,0,0,32'h0,0,0, 32'h10c,0,1,0,ERR_ON,"err_sticky");
    // reset mid-sequence, then 32-bit wrap
    step(1,0,0,32'h0,1,0, 32'h0040_0000,0,1,0,0,"reset2");
    step(0,0,1,32'hFFFF_FFFC,0,0, 32'hFFFF_FFFC,0,1,0,0,"to_top");
    step(0,0,0,32'h0,0,0, 32'h0,0,1,0,0,"wrap");
    // 9 calls into an 8-deep stack
    for (int k = 0; k < 9; k++)
      step(0,0,1,addr_t'((k+1)*16),1,0,
           addr_t'((k+1)*16), addr_t'(k*16+4), 0,
           (k >= 7), (k == 8) ? ERR_ON : 1'b0,
           $sformatf("ovf_call%0d", k));
    for (int j = 0; j < 8; j++)
      step(0,0,0,32'h0,0,1,
           addr_t'(32'h90 + 4*(j+1)),
           (j < 7) ? addr_t'(32'h74 - 16*j) : 32'h0,
           (j == 7), 0, ERR_ON,
           $sformatf("ovf_pop%0d", j));
    // call+ret replace with 3 entries
    step(1,0,0,32'h0,0,0, 32'h0040_0000,0,1,0,0,"reset3");
    step(0,0,1,32'h500,1,0, 32'h500,32'h0040_0004,0,0,0,"c3_1");
    step(0,0,1,32'h600,1,0, 32'h600,32'h504,0,0,0,"c3_2");
    step(0,0,1,32'h300,1,0, 32'h300,32'h604,0,0,0,"c3_3");
    step(0,0,0,32'h0,1,1, 32'h304,32'h304,0,0,0,"replace");
    step(0,0,0,32'h0,0,1, 32'h308,32'h504,0,0,0,"r3_1");
    step(0,0,0,32'h0,0,1, 32'h30c,32'h0040_0004,0,0,0,"r3_2");
    step(0,0,0,32'h0,0,1, 32'h310,0,1,0,0,"r3_3");
    // call+ret on empty acts as a push plus underflow
    step(0,0,0,32'h0,1,1, 32'h314,32'h314,0,0,ERR_ON,"rep_empty");
    step(0,0,0,32'h0,0,1, 32'h318,0,1,0,ERR_ON,"rep_pop");
    w = 0;
    while (sb.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    #3;
    if (sb.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer and return-address stack (RAS) for the MIPS fetch stage. It consumes the redirect request and target produced by the jump decoder (`PCSrc`, `JmpAddr`) and supplies that decoder with `PCPlus4` and `ResumeAddr`, the top of a hardware RAS. Each non-stalled cycle it advances or redirects the registered PC, pushes the return address on a call and pops it on a return.

## Interface
Parameters:
- `RAS_DEPTH`, 8: number of RAS entries. Must be a power of 2 and at least 2.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `Stall`  in  1: hold PC and RAS; `IsCall`, `IsRet` and `PCSrc` are ignored while high.
- `PCSrc`  in  1: redirect request; next PC is `JmpAddr`.
- `JmpAddr`  in  32: redirect target.
- `IsCall`  in  1: current instruction is a call; push `PCPlus4`.
- `IsRet`  in  1: current instruction is a return; pop the RAS.
- `PC`  out  32: registered program counter.
- `PCPlus4`  out  32: `PC + 4`, combinational, modulo 2^32.
- `ResumeAddr`  out  32: current RAS top, combinational from state; 32'h0 when the RAS is empty.
- `RasEmpty`  out  1: RAS count is 0.
- `RasFull`  out  1: RAS count equals `RAS_DEPTH`.
- `RasErr`  out  1: sticky overflow/underflow flag; see Configuration.

## Operation
- Next-PC selection, when `Stall` is 0:
  - `PC <= PCSrc ? JmpAddr : PC + 4`.
  - 32-bit wrap: 32'hFFFF_FFFC advances to 32'h0.
  - No alignment check on `JmpAddr`.
- RAS state:
  - Write pointer `wp`, width log2(`RAS_DEPTH`).
  - Count `cnt`, width log2(`RAS_DEPTH`)+1.
  - Top entry is `mem[wp-1]`, modulo depth.
- Push (`IsCall` only): `mem[wp] <= PCPlus4`, `wp <= wp+1`, `cnt <= min(cnt+1, RAS_DEPTH)`.
- Push when full (overflow): circular overwrite of the oldest entry, `cnt` stays at `RAS_DEPTH`, overflow event raised.
- Pop (`IsRet` only): `wp <= wp-1`, `cnt <= cnt-1`.
- Pop when empty (underflow): `wp` and `cnt` unchanged, `ResumeAddr` stays 0, underflow event raised.
- `IsCall` and `IsRet` together: replace the top with `PCPlus4`; `wp` and `cnt` unchanged.
  - If the RAS is empty: treated as a plain push, and an underflow event is raised.
- The RAS pops on `IsRet` whether or not `PCSrc` is asserted. The decoder decides whether `ResumeAddr` is actually used.
- `ResumeAddr` presented during the `IsRet` cycle is the top before the pop.

## Timing
- Reset values:
  - `PC` = `RESET_PC`, `wp` = 0, `cnt` = 0, `RasErr` = 0.
  - Therefore `PCPlus4` = `RESET_PC`+4, `ResumeAddr` = 0, `RasEmpty` = 1, `RasFull` = 0.
- Redirect latency: `PCSrc` sampled at edge N makes `PC` = `JmpAddr` after edge N.
- Push and pop take effect at the same edge; the new top is visible on `ResumeAddr` the following cycle.
- `Stall` = 1: all state holds for any number of cycles; the combinational outputs follow the held state.
- Reset has priority over `Stall` and over all other inputs.
- Reset asserted mid-sequence clears the RAS in one cycle.
- No combinational path from any input to any output.

## Configuration
- `PC_SEQ_RAS_ERR_EN` defined:
  - `RasErr` sets on any overflow or underflow event.
  - It stays set until reset.
- `PC_SEQ_RAS_ERR_EN` undefined:
  - `RasErr` is tied to 0 and no detection logic is built.
  - RAS data behaviour is otherwise identical.

## Structure
- Shared package `pc_seq_pkg`:
  - `WORD_W` = 32.
  - `INSTR_BYTES` = 4.
  - Default `RESET_PC`.
  - The `addr_t` typedef.
- One sub-module, `ras_stack`:
  - Holds the storage, pointer, count, and full/empty/error logic.
  - Has push/pop/data ports.
- `pc_sequencer` holds the PC register and the next-PC multiplexer.

## Test plan
- Reset with `RESET_PC`=32'h0040_0000, 3 idle cycles → `PC` reads 32'h0040_0000, then 32'h0040_0004, then 32'h0040_0008; `RasEmpty`=1.
- `PCSrc`=1 with `JmpAddr`=32'h0000_1000 at `PC`=32'h0040_0008 → `PC`=32'h0000_1000 next cycle; while `Stall`=1 with `PCSrc`=1, `PC` holds.
- Call at `PC`=32'h100, then call at `PC`=32'h200 → `ResumeAddr`=32'h204; return → `ResumeAddr`=32'h104; second return → `RasEmpty`=1, `ResumeAddr`=0.
- With `RAS_DEPTH`=8, 9 consecutive calls → `RasFull`=1 and `RasErr`=1 (macro defined); 8 pops return the 8 newest addresses, and the oldest is lost.
- Pop on empty → `RasErr`=1 with the macro defined, 0 without it; `cnt` stays 0.
- `IsCall` and `IsRet` together with 3 entries and `PC`=32'h300 → `ResumeAddr`=32'h304 and the count stays 3.
